// File: rtl/sysio_arb_pkg.sv
// Shared widths and FSM encodings for the two-master sysio AXI4-Lite arbiter.
package sysio_arb_pkg;

    localparam int unsigned MemAddrBus = 32;
    localparam int unsigned MemBus     = 32;
    localparam int unsigned StrbW      = 4;

    typedef enum logic {
        WIdle,
        WBusy
    } wr_state_e;

    typedef enum logic [1:0] {
        RIdle,
        RAddr,
        RResp
    } rd_state_e;

endpackage

// File: rtl/sysio_arb_if.sv
// AXI4-Lite channel bundle (AW, W, AR, R; no B) shared by masters and the sysio slave.
interface sysio_arb_if
    import sysio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = MemAddrBus,
    parameter int unsigned DATA_W = MemBus
);
    logic [ADDR_W-1:0] axi_awaddr;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [DATA_W-1:0] axi_wdata;
    logic [StrbW-1:0]  axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [DATA_W-1:0] axi_rdata;
    logic              axi_rvalid;
    logic              axi_rready;

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
        output axi_araddr, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_arready, axi_rdata, axi_rvalid
    );

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_araddr, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_arready, axi_rdata, axi_rvalid
    );
endinterface

// File: rtl/sysio_arb_rr2_arb.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to i_pri.
module rr2_arb (
    input  logic [1:0] i_req,
    input  logic       i_pri,
    output logic       o_gnt
);
    always_comb begin
        o_gnt = 1'b0;
        case (i_req)
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = i_pri;
            default: o_gnt = 1'b0;
        endcase
    end
endmodule

// File: rtl/sysio_arb.sv
// Arbitrates the sysio slave port between two AXI4-Lite masters, with independent
// round-robin write and read channels and one transaction in flight per channel.
module sysio_arb
    import sysio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = MemAddrBus,
    parameter int unsigned DATA_W = MemBus
) (
    input  logic         clk,
    input  logic         rst_n,
    sysio_arb_if.slave   m0_axi,
    sysio_arb_if.slave   m1_axi,
    sysio_arb_if.master  s_axi
);
    // ---------------- write side ----------------
    wr_state_e r_wstate, w_wstate_nxt;
    logic      r_wgnt, w_wgnt_nxt;
    logic      r_wr_pri, w_wr_pri_nxt;
    logic [1:0] w_wreq;
    logic      w_wpick;
    logic      w_wbusy;

    assign w_wreq = {m1_axi.axi_awvalid & m1_axi.axi_wvalid,
                     m0_axi.axi_awvalid & m0_axi.axi_wvalid};

    rr2_arb u_wr_arb (
        .i_req (w_wreq),
        .i_pri (r_wr_pri),
        .o_gnt (w_wpick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= WIdle;
            r_wgnt   <= 1'b0;
            r_wr_pri <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wgnt   <= w_wgnt_nxt;
            r_wr_pri <= w_wr_pri_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wgnt_nxt   = r_wgnt;
        w_wr_pri_nxt = r_wr_pri;
        case (r_wstate)
            WIdle: begin
                if (|w_wreq) begin
                    w_wstate_nxt = WBusy;
                    w_wgnt_nxt   = w_wpick;
                end
            end
            WBusy: begin
                if (s_axi.axi_awready && s_axi.axi_wready) begin
                    w_wstate_nxt = WIdle;
                    w_wr_pri_nxt = ~r_wgnt;
                end
            end
            default: w_wstate_nxt = WIdle;
        endcase
    end

    assign w_wbusy = (r_wstate == WBusy);

    logic [ADDR_W-1:0] w_awaddr;
    logic [DATA_W-1:0] w_wdata;
    assign w_awaddr = r_wgnt ? m1_axi.axi_awaddr : m0_axi.axi_awaddr;
    assign w_wdata  = r_wgnt ? m1_axi.axi_wdata  : m0_axi.axi_wdata;

    assign s_axi.axi_awaddr  = w_awaddr;
    assign s_axi.axi_wdata   = w_wdata;
    assign s_axi.axi_wstrb   = r_wgnt ? m1_axi.axi_wstrb : m0_axi.axi_wstrb;
    assign s_axi.axi_awvalid = w_wbusy & (r_wgnt ? m1_axi.axi_awvalid : m0_axi.axi_awvalid);
    assign s_axi.axi_wvalid  = w_wbusy & (r_wgnt ? m1_axi.axi_wvalid : m0_axi.axi_wvalid);

    assign m0_axi.axi_awready = w_wbusy & s_axi.axi_awready & ~r_wgnt;
    assign m1_axi.axi_awready = w_wbusy & s_axi.axi_awready &  r_wgnt;
    assign m0_axi.axi_wready  = w_wbusy & s_axi.axi_wready  & ~r_wgnt;
    assign m1_axi.axi_wready  = w_wbusy & s_axi.axi_wready  &  r_wgnt;

    // ---------------- read side ----------------
    rd_state_e r_rstate, w_rstate_nxt;
    logic      r_rgnt, w_rgnt_nxt;
    logic      r_rd_pri, w_rd_pri_nxt;
    logic      w_rpick;
    logic      w_raddr;
    logic      w_rresp;
    logic [ADDR_W-1:0] w_araddr;

    rr2_arb u_rd_arb (
        .i_req ({m1_axi.axi_arvalid, m0_axi.axi_arvalid}),
        .i_pri (r_rd_pri),
        .o_gnt (w_rpick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= RIdle;
            r_rgnt   <= 1'b0;
            r_rd_pri <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rgnt   <= w_rgnt_nxt;
            r_rd_pri <= w_rd_pri_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rgnt_nxt   = r_rgnt;
        w_rd_pri_nxt = r_rd_pri;
        case (r_rstate)
            RIdle: begin
                if (m0_axi.axi_arvalid || m1_axi.axi_arvalid) begin
                    w_rstate_nxt = RAddr;
                    w_rgnt_nxt   = w_rpick;
                end
            end
            RAddr: begin
                if (s_axi.axi_arready) w_rstate_nxt = RResp;
            end
            RResp: begin
                if (s_axi.axi_rvalid && s_axi.axi_rready) begin
                    w_rstate_nxt = RIdle;
                    w_rd_pri_nxt = ~r_rgnt;
                end
            end
            default: w_rstate_nxt = RIdle;
        endcase
    end

    assign w_raddr  = (r_rstate == RAddr);
    assign w_rresp  = (r_rstate == RResp);
    assign w_araddr = r_rgnt ? m1_axi.axi_araddr : m0_axi.axi_araddr;

    assign s_axi.axi_araddr  = w_araddr;
    assign s_axi.axi_arvalid = w_raddr & (r_rgnt ? m1_axi.axi_arvalid : m0_axi.axi_arvalid);
    assign s_axi.axi_rready  = w_rresp & (r_rgnt ? m1_axi.axi_rready : m0_axi.axi_rready);

    assign m0_axi.axi_arready = w_raddr & s_axi.axi_arready & ~r_rgnt;
    assign m1_axi.axi_arready = w_raddr & s_axi.axi_arready &  r_rgnt;
    assign m0_axi.axi_rvalid  = w_rresp & s_axi.axi_rvalid  & ~r_rgnt;
    assign m1_axi.axi_rvalid  = w_rresp & s_axi.axi_rvalid  &  r_rgnt;

    // Read data is broadcast; only the granted master sees rvalid.
    assign m0_axi.axi_rdata = s_axi.axi_rdata;
    assign m1_axi.axi_rdata = s_axi.axi_rdata;

endmodule
